bbox_msg_scheduler: RTL and testbench
=====================================

// Module: bbox_msg_scheduler
// PURPOSE
//  Schedules per-colour bounding-box reports into the shared 32-bit CPU message FIFO (MSG_FIFO).
//  Sits between the image processor's five box trackers (red/yellow/green/blue/pink) and the FIFO write port.
//  Every Nth video frame it snapshots all boxes and writes one 3-word message per enabled, non-empty box.
//  Colour order is round-robin and each message is gated on FIFO space.
// PARAMETERS
//  NUM_COL    5    number of colour trackers (index 0..4 = R,Y,G,B,P)
//  COORD_W    11   coordinate width
//  FIFO_DEPTH 256  message FIFO depth in words
//  MSG_WORDS  3    words per message
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous reset, active-high
//  frame_done    in   1    1-cycle pulse: eop & valid & video packet
//  bbox_in       in   220  colour i at [44*i +: 44] = {x_min,y_min,x_max,y_max}
//  cfg_interval  in   8    report every N frames; 0 treated as 1
//  cfg_colour_en in   5    per-colour report enable, bit i = colour i
//  fifo_usedw    in   8    FIFO fill level
//  fifo_wr       out  1    FIFO write strobe
//  fifo_data     out  32   FIFO write data
//  busy          out  1    high while state != IDLE
//  drop_count    out  16   messages/reports dropped, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: fifo_wr=0, fifo_data=0, busy=0, drop_count=0; frame_cnt=0, rr_ptr=0, state=IDLE.
//  Frame counter, evaluated on each frame_done:
//   - frame_cnt==0: launch attempt, then frame_cnt <= max(cfg_interval,1)-1.
//   - otherwise: frame_cnt <= frame_cnt-1.
//  Launch while IDLE:
//   - Snapshot bbox_in.
//   - pending[i] = cfg_colour_en[i] & (x_min<=x_max) & (y_min<=y_max).
//   - idx <= rr_ptr; rr_ptr <= (rr_ptr+1) mod 5; visited <= 0; go to SCAN.
//  Launch while busy: report skipped, drop_count += 1, counter still reloads.
//  FSM: IDLE -> SCAN -> HDR -> TL -> BR -> SCAN ... -> IDLE.
//   SCAN (1 cycle per colour):
//    - visited==5: go to IDLE.
//    - pending[idx] & (fifo_usedw < FIFO_DEPTH-2*MSG_WORDS, i.e. <250): go to HDR.
//    - pending[idx] but space test fails: drop_count += 1, advance.
//    - not pending: advance.
//    - "Advance" = idx <= (idx+1) mod 5, visited += 1.
//   HDR/TL/BR: fifo_wr=1 for exactly one cycle each, registered outputs.
//    - HDR data: {8'h00, col_char, "BB"}.
//    - TL data: {5'b0,x_min,5'b0,y_min}. BR data: {5'b0,x_max,5'b0,y_max}.
//    - col_char per index: "R","Y","G","B","P".
//    - BR then advances idx/visited and returns to SCAN.
//  Space margin: the 2*MSG_WORDS reserve covers the 1-cycle usedw update lag; no FIFO overflow is permitted.
//  Latency: frame_done at cycle T -> first fifo_wr at T+2 (SCAN at T+1).
//   Per colour: 4 cycles if written, 1 if skipped. Full report is at most 21 cycles.
//  Simultaneous events:
//   - frame_done in the cycle BR moves to SCAN still counts as busy (skip + drop).
//   - Drop increments in the same cycle are summed, then saturated.
//  cfg_* and bbox_in changes during a report do not affect it (snapshot).
//  rst mid-message: next cycle fifo_wr=0 and all state cleared. The system flushes the FIFO on the same reset.
// CONFIGURATION
//  BBOX_MSG_SEQ_EN defined:
//   - HDR[31:24] = 8-bit report sequence number.
//   - Reset 0; +1 per launched report, shared by all its messages; wraps 255->0.
//   - Skipped reports do not increment it.
//  Not defined: HDR[31:24] = 8'h00 and no sequence register exists.
// TESTING
//  1. interval=1, en=5'h1F, all boxes valid, usedw=0, frame_done -> 15 writes, order R,Y,G,B,P.
//     First is {00,"R","BB"} at T+2; busy falls after 21 cycles.
//  2. Second report, same setup -> order Y,G,B,P,R (rr_ptr=1); third starts at G.
//  3. interval=3, six frame_done pulses -> launches on pulses 1 and 4 only.
//  4. Green box x_min=639,x_max=0 (empty), en=5'h1F -> 12 writes, no "G" header, drop_count unchanged.
//  5. usedw held at 250 -> zero writes, drop_count += 5; usedw=249 -> messages written.
//  6. rst asserted on TL cycle -> fifo_wr=0 next cycle, busy=0, drop_count=0.
//     Following frame_done relaunches from colour R.
//     With BBOX_MSG_SEQ_EN: headers carry seq 0, then 1 after the next report; 255 wraps to 0.

Source files
------------

// File: rtl/bbox_msg_scheduler.sv
// -----------------------------------------------------------------------------
// bbox_msg_scheduler
//
// Turns the per-colour bounding boxes from the image processor's trackers into
// CPU messages on the shared 32-bit message FIFO.
//
// Every Nth completed video frame, all boxes are snapshotted. For each enabled,
// non-empty box, one 3-word message is written:
//   HDR : {tag, colour char, "BB"}
//   TL  : {5'b0, x_min, 5'b0, y_min}
//   BR  : {5'b0, x_max, 5'b0, y_max}
//
// The starting colour rotates from one report to the next, so no colour is
// always last when the FIFO is nearly full. A message is written only when the
// FIFO can take the whole message. Reports that cannot be launched and
// messages that cannot be written are counted in drop_count.
//
// Optional feature (compile-time macro BBOX_MSG_SEQ_EN):
//   defined     : HDR[31:24] carries an 8-bit report sequence number. It is 0
//                 after reset, increments once per launched report, is shared
//                 by every message of that report, and wraps from 255 to 0.
//   not defined : HDR[31:24] is 8'h00 and no sequence register exists.
//
// Ports
//   clk           in   1     system clock
//   rst           in   1     synchronous reset, active-high
//   frame_done    in   1     1-cycle pulse at the end of a video packet
//   bbox_in       in   220   colour i at [44*i +: 44] = {x_min,y_min,x_max,y_max}
//   cfg_interval  in   8     report every N frames (0 is treated as 1)
//   cfg_colour_en in   5     per-colour report enable
//   fifo_usedw    in   8     message FIFO fill level
//   fifo_wr       out  1     FIFO write strobe (registered)
//   fifo_data     out  32    FIFO write data (registered)
//   busy          out  1     high while a report is in progress
//   drop_count    out  16    dropped reports and messages, saturating
// -----------------------------------------------------------------------------
module bbox_msg_scheduler #(
  parameter int NUM_COL    = 5,
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 256,
  parameter int MSG_WORDS  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_done,
  input  logic [NUM_COL*4*COORD_W-1:0]    bbox_in,
  input  logic [7:0]                      cfg_interval,
  input  logic [NUM_COL-1:0]              cfg_colour_en,
  input  logic [$clog2(FIFO_DEPTH)-1:0]   fifo_usedw,
  output logic                            fifo_wr,
  output logic [31:0]                     fifo_data,
  output logic                            busy,
  output logic [15:0]                     drop_count
);

  localparam int IDX_W   = $clog2(NUM_COL);
  localparam int VIS_W   = $clog2(NUM_COL + 1);
  localparam int USEDW_W = $clog2(FIFO_DEPTH);
  localparam int PAD_W   = 16 - COORD_W;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_COL - 1);
  localparam logic [VIS_W-1:0] ALL_SEEN  = VIS_W'(NUM_COL);
  // The reserve of two messages covers the one-cycle lag between a write and
  // the FIFO's used-word count reflecting it, so the FIFO can never overflow.
  localparam logic [USEDW_W:0] SPACE_LIM = (USEDW_W + 1)'(FIFO_DEPTH - 2 * MSG_WORDS);

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_max;
  } box_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_HDR,
    S_TL,
    S_BR
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [7:0] col_char(input logic [IDX_W-1:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h52;  // "R"
      3'd1:    c = 8'h59;  // "Y"
      3'd2:    c = 8'h47;  // "G"
      3'd3:    c = 8'h42;  // "B"
      3'd4:    c = 8'h50;  // "P"
      default: c = 8'h3F;  // "?" unreachable index
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state;
  state_t                  state_next;
  logic [7:0]              frame_cnt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        idx;
  logic [VIS_W-1:0]        visited;
  logic [NUM_COL-1:0]      pending;
  box_t [NUM_COL-1:0]      snap;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  box_t [NUM_COL-1:0]      boxes_in;
  logic [NUM_COL-1:0]      pending_in;
  box_t                    cur_box;
  logic                    cur_pending;
  logic                    space_ok;
  logic                    all_visited;
  logic                    frame_hit;
  logic                    launch;
  logic                    skip_report;
  logic                    scan_drop;
  logic                    advance;
  logic [7:0]              reload;
  logic [7:0]              hdr_tag;

  assign boxes_in    = bbox_in;
  assign cur_box     = snap[idx];
  assign cur_pending = pending[idx];
  assign space_ok    = ({1'b0, fifo_usedw} < SPACE_LIM);
  assign all_visited = (visited == ALL_SEEN);

  // A launch attempt happens on the frame that brings the counter to zero.
  // If the previous report is still running (including its BR -> SCAN cycle),
  // the new report is skipped rather than queued.
  assign frame_hit   = frame_done && (frame_cnt == 8'd0);
  assign launch      = frame_hit && (state == S_IDLE);
  assign skip_report = frame_hit && (state != S_IDLE);
  assign reload      = (cfg_interval == 8'd0) ? 8'd0 : cfg_interval - 8'd1;

  assign scan_drop   = (state == S_SCAN) && !all_visited && cur_pending && !space_ok;
  assign advance     = ((state == S_SCAN) && !all_visited && !(cur_pending && space_ok))
                     || (state == S_BR);

  assign busy        = (state != S_IDLE);

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path through the block can leave it holding a latch.
  always_comb begin
    pending_in = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      pending_in[i] = cfg_colour_en[i]
                   && (boxes_in[i].x_min <= boxes_in[i].x_max)
                   && (boxes_in[i].y_min <= boxes_in[i].y_max);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (launch) state_next = S_SCAN;
      S_SCAN: begin
        if (all_visited)                   state_next = S_IDLE;
        else if (cur_pending && space_ok)  state_next = S_HDR;
        else                               state_next = S_SCAN;
      end
      S_HDR:   state_next = S_TL;
      S_TL:    state_next = S_BR;
      S_BR:    state_next = S_SCAN;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // Outputs are computed from the state being entered and registered, so the
  // write strobe is high exactly during the HDR, TL and BR cycles.
  // ---------------------------------------------------------------------------
  logic        wr_d;
  logic [31:0] data_d;

  always_comb begin
    wr_d   = 1'b0;
    data_d = '0;
    case (state_next)
      S_HDR: begin
        wr_d   = 1'b1;
        data_d = {hdr_tag, col_char(idx), 16'h4242};
      end
      S_TL: begin
        wr_d   = 1'b1;
        data_d = {{PAD_W{1'b0}}, cur_box.x_min, {PAD_W{1'b0}}, cur_box.y_min};
      end
      S_BR: begin
        wr_d   = 1'b1;
        data_d = {{PAD_W{1'b0}}, cur_box.x_max, {PAD_W{1'b0}}, cur_box.y_max};
      end
      default: begin
        wr_d   = 1'b0;
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
    end else begin
      fifo_wr   <= wr_d;
      fifo_data <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'd0;
      rr_ptr    <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt <= (frame_cnt == 8'd0) ? reload : frame_cnt - 8'd1;
      end
      if (launch) begin
        rr_ptr <= next_idx(rr_ptr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Report snapshot and scan position
  // ---------------------------------------------------------------------------
  // NOTE: the snapshot is reset along with everything else, so a reset
  // mid-report leaves no stale box data.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap    <= '0;
      pending <= '0;
      idx     <= '0;
      visited <= '0;
    end else if (launch) begin
      snap    <= boxes_in;
      pending <= pending_in;
      idx     <= rr_ptr;
      visited <= '0;
    end else if (advance) begin
      idx     <= next_idx(idx);
      visited <= visited + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: a skipped report and a message dropped in the same cycle
  // both count, and the sum saturates.
  // ---------------------------------------------------------------------------
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign drop_inc = {1'b0, skip_report} + {1'b0, scan_drop};
  assign drop_sum = {1'b0, drop_count} + {15'b0, drop_inc};

  always_ff @(posedge clk) begin
    if (rst) drop_count <= 16'd0;
    else     drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // ---------------------------------------------------------------------------
  // Header tag
  // ---------------------------------------------------------------------------
`ifdef BBOX_MSG_SEQ_EN
  logic [7:0] seq_cnt;
  logic [7:0] report_seq;

  // seq_cnt is the number for the next report; report_seq holds the number
  // of the report in progress so all of its headers agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt    <= 8'd0;
      report_seq <= 8'd0;
    end else if (launch) begin
      seq_cnt    <= seq_cnt + 8'd1;
      report_seq <= seq_cnt;
    end
  end

  assign hdr_tag = report_seq;
`else
  assign hdr_tag = 8'h00;
`endif

endmodule

// File: tb/tb_bbox_msg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bbox_msg_scheduler
//
// Directed bench for bbox_msg_scheduler. Inputs change on the falling edge,
// outputs are sampled on the falling edge. A monitor logs every FIFO write
// with the cycle it appeared in; each report is checked word by word against
// expected messages built from the box table and the expected colour order.
// -----------------------------------------------------------------------------
module tb_bbox_msg_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_done;
  logic [219:0] bbox_in;
  logic [7:0]   cfg_interval;
  logic [4:0]   cfg_colour_en;
  logic [7:0]   fifo_usedw;
  logic         fifo_wr;
  logic [31:0]  fifo_data;
  logic         busy;
  logic [15:0]  drop_count;

  bbox_msg_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .frame_done    (frame_done),
    .bbox_in       (bbox_in),
    .cfg_interval  (cfg_interval),
    .cfg_colour_en (cfg_colour_en),
    .fifo_usedw    (fifo_usedw),
    .fifo_wr       (fifo_wr),
    .fifo_data     (fifo_data),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wq[$];
  int          wc[$];
  always @(negedge clk) begin
    if (fifo_wr) begin
      wq.push_back(fifo_data);
      wc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int exp_seq  = 0;

  logic [10:0] xmin[5], ymin[5], xmax[5], ymax[5];
  logic [7:0]  chars[5] = '{8'h52, 8'h59, 8'h47, 8'h42, 8'h50};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_boxes();
    for (int i = 0; i < 5; i++)
      bbox_in[44*i +: 44] = {xmin[i], ymin[i], xmax[i], ymax[i]};
  endtask

  function automatic logic [31:0] exp_hdr(input int c, input int seq);
`ifdef BBOX_MSG_SEQ_EN
    return {8'(seq), chars[c], 16'h4242};
`else
    return {8'h00 + 8'(seq & 0), chars[c], 16'h4242};
`endif
  endfunction

  function automatic logic [31:0] exp_tl(input int c);
    return {5'b0, xmin[c], 5'b0, ymin[c]};
  endfunction

  function automatic logic [31:0] exp_br(input int c);
    return {5'b0, xmax[c], 5'b0, ymax[c]};
  endfunction

  function automatic logic [4:0][2:0] rot(input int s);
    logic [4:0][2:0] r;
    for (int i = 0; i < 5; i++) r[i] = 3'((s + i) % 5);
    return r;
  endfunction

  // Raise frame_done for one cycle; t0 is the cycle in which it is high.
  task automatic pulse(output int t0);
    @(negedge clk);
    frame_done = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(output int fall);
    fall = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
  endtask

  // One launched report writing n messages in colour order ord[0..n-1].
  // skip_off > 0 raises a second frame_done skip_off cycles after the first,
  // while the report is still running.
  task automatic run_report(input string name, input int n,
                            input logic [4:0][2:0] ord, input int skip_off);
    int t0, t1, fall, c;
    wq.delete();
    wc.delete();
    pulse(t0);
    if (skip_off > 0) begin
      repeat (skip_off - 2) @(negedge clk);
      pulse(t1);
    end
    wait_idle(fall);
    check({name, " busy_fall"}, 32'(fall), 32'(t0 + 3 * n + 7));
    check({name, " n_writes"}, 32'(wq.size()), 32'(3 * n));
    if (n > 0 && wc.size() > 0)
      check({name, " first_wr_cycle"}, 32'(wc[0]), 32'(t0 + 2));
    for (int i = 0; i < n; i++) begin
      if (wq.size() >= 3 * i + 3) begin
        c = int'(ord[i]);
        check($sformatf("%s hdr%0d", name, i), wq[3*i],   exp_hdr(c, exp_seq));
        check($sformatf("%s tl%0d",  name, i), wq[3*i+1], exp_tl(c));
        check($sformatf("%s br%0d",  name, i), wq[3*i+2], exp_br(c));
      end
    end
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic no_launch(input string name);
    int t0;
    wq.delete();
    pulse(t0);
    repeat (8) @(negedge clk);
    check({name, " n_writes"}, 32'(wq.size()), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int t0;
    rst           = 1'b1;
    frame_done    = 1'b0;
    bbox_in       = '0;
    cfg_interval  = 8'd1;
    cfg_colour_en = 5'h1F;
    fifo_usedw    = 8'd0;
    for (int i = 0; i < 5; i++) begin
      xmin[i] = 11'(16 * i + 1);
      ymin[i] = 11'(32 * i + 2);
      xmax[i] = 11'(600 + i);
      ymax[i] = 11'(400 + i);
    end
    apply_boxes();

    repeat (3) @(negedge clk);
    check("reset fifo_wr",    32'(fifo_wr),    32'd0);
    check("reset fifo_data",  fifo_data,       32'd0);
    check("reset busy",       32'(busy),       32'd0);
    check("reset drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: full report from red, first word hand-computed
    run_report("rep1", 5, rot(0), 0);
    check("rep1 hdr_R_const", wq[0], 32'h0052_4242);
    check("rep1 tl_R_const",  wq[1], 32'h0001_0002);
    check("rep1 br_R_const",  wq[2], 32'h0258_0190);

    // 2: round robin continues with yellow, then green
    run_report("rep2", 5, rot(1), 0);
    run_report("rep3", 5, rot(2), 0);

    // 3: interval 3, launches only on pulses 1 and 4
    cfg_interval = 8'd3;
    run_report("int3_p1", 5, rot(3), 0);
    no_launch("int3_p2");
    no_launch("int3_p3");
    run_report("int3_p4", 5, rot(4), 0);
    no_launch("int3_p5");
    no_launch("int3_p6");
    cfg_interval = 8'd1;

    // 4: empty green box is silently skipped
    xmin[2] = 11'd639;
    xmax[2] = 11'd0;
    apply_boxes();
    run_report("empty_g", 4, {3'd0, 3'd4, 3'd3, 3'd1, 3'd0}, 0);
    check("empty_g drop", 32'(drop_count), 32'd0);
    xmin[2] = 11'(33);
    xmax[2] = 11'(602);
    apply_boxes();

    // 5: no space at 250, space at 249
    fifo_usedw = 8'd250;
    run_report("full250", 0, rot(0), 0);
    check("full250 drop", 32'(drop_count), 32'd5);
    fifo_usedw = 8'd249;
    run_report("ok249", 5, rot(2), 0);
    check("ok249 drop", 32'(drop_count), 32'd5);
    fifo_usedw = 8'd0;

    // frame_done on the BR -> SCAN cycle: skipped, counted, report intact
    run_report("busy_skip", 5, rot(3), 4);
    check("busy_skip drop", 32'(drop_count), 32'd6);

    // 6: reset during TL
    wq.delete();
    pulse(t0);
    @(negedge clk);
    check("rst hdr_wr",   32'(fifo_wr), 32'd1);
    check("rst hdr_data", fifo_data,    exp_hdr(4, exp_seq));
    @(negedge clk);
    check("rst tl_wr",    32'(fifo_wr), 32'd1);
    check("rst tl_data",  fifo_data,    exp_tl(4));
    rst = 1'b1;
    @(negedge clk);
    check("rst after fifo_wr", 32'(fifo_wr),    32'd0);
    check("rst after busy",    32'(busy),       32'd0);
    check("rst after drop",    32'(drop_count), 32'd0);
    rst = 1'b0;
    exp_seq = 0;
    @(negedge clk);
    run_report("relaunch", 5, rot(0), 0);
    run_report("relaunch2", 5, rot(1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
